line_mem: RTL and testbench

LINE_MEM -- requirements
Module: line_mem

---
 rtl/line_mem.sv | 154 +++++++++++++++
 tb/tb_line_mem.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/line_mem.sv
// line_mem: single-port 256-bit line store with a fixed request-to-ack latency.
// Optional per-direction completion counters are built only when LINE_MEM_STATS_EN is defined.
module line_mem #(
    parameter int LATENCY    = 10,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic [255:0] data_o,
    output logic         ack_o,
    output logic [31:0]  rd_count_o,
    output logic [31:0]  wr_count_o,
    output logic [1:0]   state_o
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    localparam int          LINES = 1 << DEPTH_LOG2;
    localparam logic [7:0]  LOAD  = 8'(LATENCY - 2);

    // Handshake: a request is taken when enable_i is high while IDLE; the
    // requester keeps it up until ack_o, but nothing is sampled after acceptance.

    logic [1:0]            state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                  wr_q, wr_d;
    logic [255:0]          wdata_q, wdata_d;
    logic [255:0]          data_q, data_d;
    logic                  ack_q, ack_d;
    logic                  mem_we;
    logic                  complete;

    logic [255:0] mem [0:LINES-1];

    // Bits outside the line index select nothing; aliases map silently.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:DEPTH_LOG2+5], addr_i[4:0]};

    assign complete = (state_q == WAIT) && (cnt_q == 8'd0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        ack_d   = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable_i) begin
                    state_d = WAIT;
                    cnt_d   = LOAD;
                    idx_d   = addr_i[DEPTH_LOG2+4:5];
                    wr_d    = write_i;
                    wdata_d = data_i;
                end
            end
            WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                    if (wr_q) begin
                        mem_we = 1'b1;
                    end else begin
                        data_d = mem[idx_q];
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            data_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            ack_q   <= ack_d;
        end
    end

    // Array is not reset; a reset edge also suppresses a write due that edge.
    always_ff @(posedge clk_i) begin
        if (rst_i && mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

`ifdef LINE_MEM_STATS_EN
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (complete && !wr_q) begin
            rd_count_d = rd_count_q + 32'd1;
        end
        if (complete && wr_q) begin
            wr_count_d = wr_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rd_count_q <= 32'd0;
            wr_count_q <= 32'd0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count_o = rd_count_q;
    assign wr_count_o = wr_count_q;
`else
    logic unused_complete;
    assign unused_complete = complete;
    assign rd_count_o = 32'd0;
    assign wr_count_o = 32'd0;
`endif

    assign data_o  = data_q;
    assign ack_o   = ack_q;
    assign state_o = state_q;

endmodule

// File: tb/tb_line_mem.sv
// Self-checking bench for line_mem: ack latency, read/write data, aliasing,
// mid-operation input changes, reset mid-request and the optional counters.
module tb_line_mem;

  localparam int LATENCY    = 10;
  localparam int DEPTH_LOG2 = 9;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         enable_i;
  logic         write_i;
  logic [31:0]  addr_i;
  logic [255:0] data_i;
  logic [255:0] data_o;
  logic         ack_o;
  logic [31:0]  rd_count_o;
  logic [31:0]  wr_count_o;
  logic [1:0]   state_o;

  line_mem #(.LATENCY(LATENCY), .DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .enable_i   (enable_i),
    .write_i    (write_i),
    .addr_i     (addr_i),
    .data_i     (data_i),
    .data_o     (data_o),
    .ack_o      (ack_o),
    .rd_count_o (rd_count_o),
    .wr_count_o (wr_count_o),
    .state_o    (state_o)
  );

  always #5 clk_i = ~clk_i;

  // scoreboard state
  logic [255:0] exp_q[$];
  logic [255:0] model [0:(1<<DEPTH_LOG2)-1];
  logic [255:0] last_rd;
  logic [31:0]  rd_exp;
  logic [31:0]  wr_exp;
  int           n_cmp;
  int           n_bad;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic count_done(input logic wr);
`ifdef LINE_MEM_STATS_EN
    if (wr) wr_exp = wr_exp + 32'd1;
    else    rd_exp = rd_exp + 32'd1;
`else
    if (wr) wr_exp = wr_exp;
`endif
  endtask

  // One request; optionally drop enable_i and scramble inputs drop_at cycles after accept.
  task automatic do_op(input logic wr, input logic [31:0] addr, input logic [255:0] wdata,
                       input int drop_at, input logic [31:0] alt_addr);
    int k;
    bit seen;
    logic [DEPTH_LOG2-1:0] idx;
    idx = addr[DEPTH_LOG2+4:5];
    @(negedge clk_i);
    enable_i = 1'b1;
    write_i  = wr;
    addr_i   = addr;
    data_i   = wdata;
    if (!wr) exp_q.push_back(model[idx]);
    @(posedge clk_i);
    seen = 0;
    k = 0;
    while (!seen && k < 200) begin
      @(negedge clk_i);
      if (k + 1 == drop_at) begin
        enable_i = 1'b0;
        addr_i   = alt_addr;
        data_i   = ~wdata;
        write_i  = ~wr;
      end
      if (ack_o) seen = 1;
      else k++;
    end
    enable_i = 1'b0;
    check("ack_latency", 256'(k + 1), 256'(LATENCY));
    if (wr) begin
      model[idx] = wdata;
      check("data_hold_on_write", data_o, last_rd);
    end else begin
      last_rd = exp_q.pop_front();
      check("read_data", data_o, last_rd);
    end
    count_done(wr);
    check("rd_count", 256'(rd_count_o), 256'(rd_exp));
    check("wr_count", 256'(wr_count_o), 256'(wr_exp));
    @(negedge clk_i);
    check("ack_one_cycle", 256'(ack_o), 256'(0));
  endtask

  task automatic idle_no_ack(input int cycles, input string tag);
    int acks;
    acks = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk_i);
      if (ack_o) acks++;
    end
    check(tag, 256'(acks), 256'(0));
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i    = 1'b0;
    enable_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i   = 1'b1;
    last_rd = '0;
    rd_exp  = '0;
    wr_exp  = '0;
  endtask

  logic [31:0]  lines [0:4];
  logic [255:0] rnd;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_i = 1'b1;
    enable_i = 1'b0;
    write_i = 1'b0;
    addr_i = '0;
    data_i = '0;
    for (int i = 0; i < (1 << DEPTH_LOG2); i++) model[i] = '0;
    lines[0] = 32'h40; lines[1] = 32'h60; lines[2] = 32'h80;
    lines[3] = 32'h100; lines[4] = 32'h200;

    // reset state
    do_reset();
    check("rst_ack", 256'(ack_o), 256'(0));
    check("rst_data", data_o, '0);
    check("rst_rd_count", 256'(rd_count_o), 256'(0));
    check("rst_wr_count", 256'(wr_count_o), 256'(0));
    check("rst_state", 256'(state_o), 256'(0));
    idle_no_ack(20, "idle_ack");

    // write then read
    do_op(1'b1, 32'h40, {8{32'hA5A5_0001}}, 0, '0);
    do_op(1'b0, 32'h40, '0, 0, '0);
    check("wr_rd_value", data_o, {8{32'hA5A5_0001}});

    // aliasing and byte offset
    do_op(1'b1, 32'h60, {4{64'h0123_4567_89AB_CDEF}}, 0, '0);
    do_op(1'b0, 32'h0000_407F, '0, 0, '0);
    check("alias_value", data_o, {4{64'h0123_4567_89AB_CDEF}});

    // mid-operation input changes
    do_op(1'b1, 32'h200, {8{32'hEEEE_0200}}, 0, '0);
    do_op(1'b1, 32'h80, {8{32'hF00D_0080}}, 3, 32'h200);
    do_op(1'b0, 32'h80, '0, 0, '0);
    check("mid_orig_line", data_o, {8{32'hF00D_0080}});
    do_op(1'b0, 32'h200, '0, 0, '0);
    check("mid_other_line", data_o, {8{32'hEEEE_0200}});

    // reset during WAIT of a write
    do_op(1'b1, 32'h100, {8{32'h1111_0100}}, 0, '0);
    @(negedge clk_i);
    enable_i = 1'b1;
    write_i  = 1'b1;
    addr_i   = 32'h100;
    data_i   = {8{32'hDEAD_BEEF}};
    @(posedge clk_i);
    repeat (3) @(negedge clk_i);
    check("pre_reset_state", 256'(state_o), 256'(1));
    do_reset();
    check("post_reset_data", data_o, '0);
    idle_no_ack(20, "aborted_ack");
    check("aborted_wr_count", 256'(wr_count_o), 256'(0));
    do_op(1'b0, 32'h100, '0, 0, '0);
    check("aborted_write_line", data_o, {8{32'h1111_0100}});

    // random traffic over written lines with garbage offset/upper bits
    for (int i = 0; i < 12; i++) begin
      logic [31:0] a;
      a = lines[$urandom_range(0, 4)] | ($urandom_range(0, 255) << 14) | $urandom_range(0, 31);
      rnd = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      do_op(1'($urandom_range(0, 1)), a, rnd, 0, '0);
    end

`ifdef LINE_MEM_STATS_EN
    // counter wrap
    do_reset();
    @(negedge clk_i);
    force dut.rd_count_q = 32'hFFFF_FFFF;
    @(negedge clk_i);
    release dut.rd_count_q;
    rd_exp = 32'hFFFF_FFFF;
    do_op(1'b0, 32'h40, '0, 0, '0);
    check("rd_wrap", 256'(rd_count_o), 256'(0));
`else
    check("no_stats_rd", 256'(rd_count_o), 256'(0));
    check("no_stats_wr", 256'(wr_count_o), 256'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
